// File: rtl/noc_credit_link.sv
// Pipelined router-to-router link per channel: flit and credit paths delayed NUM_PIPELINE cycles (0 = wires), credit counter, packet FSM, sticky errors.
// No backpressure: can_send is advisory and flits are always forwarded; NOC_CREDIT_LINK_STATS_EN adds flit/packet counters.
module noc_credit_link #(
  parameter int NUM_CHANNELS = 4,
  parameter int FLIT_WIDTH   = 128,
  parameter int DEST_WIDTH   = 6,
  parameter int NUM_PIPELINE = 2,
  parameter int CREDIT_DEPTH = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                             clk_noc,
  input  logic                                             rst_noc,
  input  logic [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0]          data_in,
  input  logic [0:NUM_CHANNELS-1][DEST_WIDTH-1:0]          dest_in,
  input  logic [0:NUM_CHANNELS-1]                          is_tail_in,
  input  logic [0:NUM_CHANNELS-1]                          send_in,
  output logic [0:NUM_CHANNELS-1]                          credit_out,
  output logic [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0]          data_out,
  output logic [0:NUM_CHANNELS-1][DEST_WIDTH-1:0]          dest_out,
  output logic [0:NUM_CHANNELS-1]                          is_tail_out,
  output logic [0:NUM_CHANNELS-1]                          send_out,
  input  logic [0:NUM_CHANNELS-1]                          credit_in,
  output logic [0:NUM_CHANNELS-1]                          can_send,
  output logic [0:NUM_CHANNELS-1][$clog2(CREDIT_DEPTH+1)-1:0] credit_count,
  output logic [0:NUM_CHANNELS-1]                          pkt_open,
  output logic [0:NUM_CHANNELS-1]                          overflow_err,
  output logic [0:NUM_CHANNELS-1]                          underflow_err
`ifdef NOC_CREDIT_LINK_STATS_EN
  ,
  input  logic                                             stats_clr,
  output logic [0:NUM_CHANNELS-1][CNT_WIDTH-1:0]           flit_count,
  output logic [0:NUM_CHANNELS-1][CNT_WIDTH-1:0]           pkt_count
`endif
);

  localparam int            CW      = $clog2(CREDIT_DEPTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_DEPTH);
  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_BODY = 1'b1;

  typedef struct packed {
    logic                  send;
    logic                  tail;
    logic [DEST_WIDTH-1:0] dest;
    logic [FLIT_WIDTH-1:0] data;
  } flit_t;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    flit_t         flit_in_c;
    flit_t         flit_out_c;
    logic          crd_c;
    logic          snd_c;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          unf_q;
    logic [0:0]    st_q;

    assign snd_c     = send_in[c];
    assign flit_in_c = '{send: send_in[c], tail: is_tail_in[c], dest: dest_in[c], data: data_in[c]};

    if (NUM_PIPELINE == 0) begin : g_comb
      assign flit_out_c = flit_in_c;
      assign crd_c      = credit_in[c];
    end else begin : g_pipe
      flit_t fwd_q [NUM_PIPELINE];
      logic  crd_q [NUM_PIPELINE];

      always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
          for (int s = 0; s < NUM_PIPELINE; s++) begin
            fwd_q[s] <= '0;
            crd_q[s] <= 1'b0;
          end
        end else begin
          fwd_q[0] <= flit_in_c;
          crd_q[0] <= credit_in[c];
          for (int s = 1; s < NUM_PIPELINE; s++) begin
            fwd_q[s] <= fwd_q[s-1];
            crd_q[s] <= crd_q[s-1];
          end
        end
      end

      assign flit_out_c = fwd_q[NUM_PIPELINE-1];
      assign crd_c      = crd_q[NUM_PIPELINE-1];
    end

    // The counter is fed by the delayed credit, i.e. the credit as seen by upstream.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
        cnt_q <= CNT_MAX;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
        st_q  <= ST_IDLE;
      end else begin
        if (snd_c && !crd_c) begin
          if (cnt_q == '0) ovf_q <= 1'b1;
          else             cnt_q <= cnt_q - CW'(1);
        end else if (crd_c && !snd_c) begin
          if (cnt_q == CNT_MAX) unf_q <= 1'b1;
          else                  cnt_q <= cnt_q + CW'(1);
        end
        if (snd_c) begin
          case (st_q)
            ST_IDLE: if (!is_tail_in[c]) st_q <= ST_BODY;
            default: if (is_tail_in[c])  st_q <= ST_IDLE;
          endcase
        end
      end
    end

    assign data_out[c]      = flit_out_c.data;
    assign dest_out[c]      = flit_out_c.dest;
    assign is_tail_out[c]   = flit_out_c.tail;
    assign send_out[c]      = flit_out_c.send;
    assign credit_out[c]    = crd_c;
    assign credit_count[c]  = cnt_q;
    assign can_send[c]      = (cnt_q != '0);
    assign pkt_open[c]      = (st_q == ST_BODY);
    assign overflow_err[c]  = ovf_q;
    assign underflow_err[c] = unf_q;

`ifdef NOC_CREDIT_LINK_STATS_EN
    logic [CNT_WIDTH-1:0] flit_q;
    logic [CNT_WIDTH-1:0] pkt_q;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
        flit_q <= '0;
        pkt_q  <= '0;
      end else if (stats_clr) begin
        flit_q <= '0;
        pkt_q  <= '0;
      end else begin
        if (snd_c)                  flit_q <= flit_q + CNT_WIDTH'(1);
        if (snd_c && is_tail_in[c]) pkt_q  <= pkt_q + CNT_WIDTH'(1);
      end
    end

    assign flit_count[c] = flit_q;
    assign pkt_count[c]  = pkt_q;
`endif
  end

endmodule

// File: tb/tb_noc_credit_link.sv
// Directed bench for noc_credit_link: NUM_PIPELINE=2, CREDIT_DEPTH=2, CNT_WIDTH=4, hand-computed expectations.
module tb_noc_credit_link;
  localparam int NC = 4;
  localparam int FW = 16;
  localparam int DW = 6;
  localparam int NP = 2;
  localparam int CD = 2;
  localparam int CN = 4;
  localparam int CW = $clog2(CD+1);

  logic                   clk_noc = 1'b0;
  logic                   rst_noc = 1'b1;
  logic [0:NC-1][FW-1:0]  data_in = '0;
  logic [0:NC-1][DW-1:0]  dest_in = '0;
  logic [0:NC-1]          is_tail_in = '0;
  logic [0:NC-1]          send_in = '0;
  logic [0:NC-1]          credit_out;
  logic [0:NC-1][FW-1:0]  data_out;
  logic [0:NC-1][DW-1:0]  dest_out;
  logic [0:NC-1]          is_tail_out;
  logic [0:NC-1]          send_out;
  logic [0:NC-1]          credit_in = '0;
  logic [0:NC-1]          can_send;
  logic [0:NC-1][CW-1:0]  credit_count;
  logic [0:NC-1]          pkt_open;
  logic [0:NC-1]          overflow_err;
  logic [0:NC-1]          underflow_err;
`ifdef NOC_CREDIT_LINK_STATS_EN
  logic                   stats_clr = 1'b0;
  logic [0:NC-1][CN-1:0]  flit_count;
  logic [0:NC-1][CN-1:0]  pkt_count;
`endif

  int checks   = 0;
  int failures = 0;

  noc_credit_link #(
    .NUM_CHANNELS(NC), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .NUM_PIPELINE(NP), .CREDIT_DEPTH(CD), .CNT_WIDTH(CN)
  ) dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in), .can_send(can_send), .credit_count(credit_count),
    .pkt_open(pkt_open), .overflow_err(overflow_err), .underflow_err(underflow_err)
`ifdef NOC_CREDIT_LINK_STATS_EN
    , .stats_clr(stats_clr), .flit_count(flit_count), .pkt_count(pkt_count)
`endif
  );

  always #5 clk_noc = ~clk_noc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_send_out",   64'(send_out), 64'h0);
    check("rst_credit_out", 64'(credit_out), 64'h0);
    check("rst_data_out",   64'(data_out), 64'h0);
    check("rst_count",      64'(credit_count), 64'hAA);
    check("rst_can_send",   64'(can_send), 64'hF);
    check("rst_pkt_open",   64'(pkt_open), 64'h0);
    check("rst_errs",       64'({overflow_err, underflow_err}), 64'h0);
    rst_noc = 1'b0;

    // Flit on channel 1 appears exactly two cycles later, alone
    send_in[1] = 1'b1; data_in[1] = 16'h00A5; dest_in[1] = 6'h15;
    tick();
    send_in = '0; data_in = '0; dest_in = '0;
    check("lat_cycle1_send_out", 64'(send_out), 64'h0);
    check("lat_count1_dec",      64'(credit_count[1]), 64'd1);
    tick();
    check("lat_cycle2_send_out", 64'(send_out), 64'b0100);
    check("lat_cycle2_data1",    64'(data_out[1]), 64'h00A5);
    check("lat_cycle2_dest1",    64'(dest_out[1]), 64'h15);
    check("lat_cycle2_data0",    64'(data_out[0]), 64'h0);
    tick();
    check("lat_cycle3_send_out", 64'(send_out), 64'h0);

    // Credit return on channel 1
    credit_in[1] = 1'b1;
    tick();
    credit_in = '0;
    check("crd_cycle1",       64'(credit_out), 64'h0);
    tick();
    check("crd_cycle2",       64'(credit_out), 64'b0100);
    check("crd_count_before", 64'(credit_count[1]), 64'd1);
    tick();
    check("crd_count_after",  64'(credit_count[1]), 64'd2);
    check("crd_cycle3",       64'(credit_out), 64'h0);

    // Three sends on channel 2 without credits
    send_in[2] = 1'b1; is_tail_in[2] = 1'b1;
    tick();
    check("ovf_count_1", 64'(credit_count[2]), 64'd1);
    check("ovf_can_1",   64'(can_send), 64'hF);
    tick();
    check("ovf_count_0", 64'(credit_count[2]), 64'd0);
    check("ovf_can_0",   64'(can_send), 64'b1101);
    check("ovf_not_yet", 64'(overflow_err), 64'h0);
    tick();
    send_in = '0; is_tail_in = '0;
    check("ovf_count_hold", 64'(credit_count[2]), 64'd0);
    check("ovf_set",        64'(overflow_err), 64'b0010);

    // Channel 3 to zero, then send and credit coincide; channel 0 gets an excess credit
    send_in[3] = 1'b1; is_tail_in[3] = 1'b1;
    tick();
    tick();
    send_in = '0; is_tail_in = '0;
    check("coin_count3_zero", 64'(credit_count[3]), 64'd0);
    credit_in[3] = 1'b1; credit_in[0] = 1'b1;
    tick();
    credit_in = '0;
    tick();
    check("coin_credit_out", 64'(credit_out), 64'b1001);
    send_in[3] = 1'b1; is_tail_in[3] = 1'b1;
    tick();
    send_in = '0; is_tail_in = '0;
    check("coin_count3",   64'(credit_count[3]), 64'd0);
    check("coin_no_ovf",   64'(overflow_err), 64'b0010);
    check("unf_set",       64'(underflow_err), 64'b1000);
    check("unf_count_hold", 64'(credit_count[0]), 64'd2);
    tick();
    tick();
    check("sticky_errs", 64'({overflow_err, underflow_err}), 64'b0010_1000);

    // Reset mid-packet with flits in the pipe
    send_in[1] = 1'b1; dest_in[1] = 6'h2A;
    tick();
    check("mid_pkt_open", 64'(pkt_open), 64'b0100);
    tick();
    check("mid_send_out", 64'(send_out), 64'b0100);
    rst_noc = 1'b1;
    #1;
    check("mid_rst_send_out",   64'(send_out), 64'h0);
    check("mid_rst_credit_out", 64'(credit_out), 64'h0);
    check("mid_rst_count",      64'(credit_count), 64'hAA);
    check("mid_rst_pkt_open",   64'(pkt_open), 64'h0);
    check("mid_rst_errs",       64'({overflow_err, underflow_err}), 64'h0);
    send_in = '0; dest_in = '0;
    tick();
    rst_noc = 1'b0;

    // Head, body, tail, single-flit packet on channel 0
    send_in[0] = 1'b1; is_tail_in[0] = 1'b0;
    tick();
    check("fsm_head", 64'(pkt_open), 64'b1000);
    tick();
    check("fsm_body", 64'(pkt_open), 64'b1000);
    is_tail_in[0] = 1'b1;
    tick();
    check("fsm_tail", 64'(pkt_open), 64'h0);
    tick();
    send_in = '0; is_tail_in = '0;
    check("fsm_single",    64'(pkt_open), 64'h0);
    check("fsm_count0",    64'(credit_count[0]), 64'd0);
    check("fsm_ovf",       64'(overflow_err), 64'b1000);
`ifdef NOC_CREDIT_LINK_STATS_EN
    check("stats_flit0", 64'(flit_count[0]), 64'd4);
    check("stats_pkt0",  64'(pkt_count[0]), 64'd2);

    // 17 single-flit packets on channel 2 wrap a 4-bit counter to 1
    send_in[2] = 1'b1; is_tail_in[2] = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    send_in = '0; is_tail_in = '0;
    check("stats_wrap_flit2", 64'(flit_count[2]), 64'd1);
    check("stats_wrap_pkt2",  64'(pkt_count[2]), 64'd1);
    stats_clr = 1'b1; send_in[2] = 1'b1; is_tail_in[2] = 1'b1;
    tick();
    stats_clr = 1'b0; send_in = '0; is_tail_in = '0;
    check("stats_clr_flit2", 64'(flit_count[2]), 64'd0);
    check("stats_clr_pkt2",  64'(pkt_count[2]), 64'd0);
    check("stats_clr_flit0", 64'(flit_count[0]), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
